// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: operation encodings, instruction field codes
// and helpers that classify decodes touching the HI/LO unit.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_AND  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_XOR  = 4'd9,
      ALU_NOR  = 4'd10,
      ALU_SLTU = 4'd11,
      ALU_LUI  = 4'd12,
      ALU_MULT = 4'd13,
      ALU_DIV  = 4'd14,
      ALU_MFHL = 4'd15
   } aluop_e;

   // How a decode interacts with the HI/LO unit.
   typedef enum logic [1:0] {
      KIND_PLAIN,
      KIND_MULT,
      KIND_DIV,
      KIND_MFHL
   } kind_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   function automatic logic is_hilo_start(input kind_e kind);
      return (kind == KIND_MULT) || (kind == KIND_DIV);
   endfunction

   function automatic logic is_mfhl(input kind_e kind);
      return kind == KIND_MFHL;
   endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational MIPS-I ALU-control decode of opcode/funct.
module alu_decode_comb
   import alu_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output aluop_e     aluop_o,
   output logic       alusrc_imm_o,
   output logic       uses_shamt_o,
   output logic       illegal_o,
   output kind_e      kind_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves one unassigned, which would infer a latch.
      aluop_o      = ALU_NOP;
      alusrc_imm_o = 1'b0;
      uses_shamt_o = 1'b0;
      illegal_o    = 1'b0;
      kind_o       = KIND_PLAIN;

      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               F_SLL: begin aluop_o = ALU_SLL; uses_shamt_o = 1'b1; end
               F_SRL: begin aluop_o = ALU_SRL; uses_shamt_o = 1'b1; end
               F_SRA: begin aluop_o = ALU_SRA; uses_shamt_o = 1'b1; end
               F_ADD, F_ADDU:   aluop_o = ALU_ADD;
               F_SUB, F_SUBU:   aluop_o = ALU_SUB;
               F_AND:           aluop_o = ALU_AND;
               F_OR:            aluop_o = ALU_OR;
               F_XOR:           aluop_o = ALU_XOR;
               F_NOR:           aluop_o = ALU_NOR;
               F_SLT:           aluop_o = ALU_SLT;
               F_SLTU:          aluop_o = ALU_SLTU;
               F_MULT, F_MULTU: begin aluop_o = ALU_MULT; kind_o = KIND_MULT; end
               F_DIV, F_DIVU:   begin aluop_o = ALU_DIV;  kind_o = KIND_DIV;  end
               F_MFHI, F_MFLO:  begin aluop_o = ALU_MFHL; kind_o = KIND_MFHL; end
               default:         illegal_o = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin aluop_o = ALU_ADD;  alusrc_imm_o = 1'b1; end
         OP_ANDI:  begin aluop_o = ALU_AND;  alusrc_imm_o = 1'b1; end
         OP_ORI:   begin aluop_o = ALU_OR;   alusrc_imm_o = 1'b1; end
         OP_XORI:  begin aluop_o = ALU_XOR;  alusrc_imm_o = 1'b1; end
         OP_SLTI:  begin aluop_o = ALU_SLT;  alusrc_imm_o = 1'b1; end
         OP_SLTIU: begin aluop_o = ALU_SLTU; alusrc_imm_o = 1'b1; end
         OP_LUI:   begin aluop_o = ALU_LUI;  alusrc_imm_o = 1'b1; end
         // Branches compare by subtraction on two registers.
         OP_BEQ, OP_BNE: aluop_o = ALU_SUB;
         default:        illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered, handshaked ALU-control issue stage with HI/LO unit interlock:
// decode -> valid/ready output register, plus a mult/div latency countdown.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int ALUOP_W  = 4,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic [4:0]         shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ALUOP_W-1:0] aluop,
   output logic               alusrc_imm,
   output logic [4:0]         shamt_out,
   output logic               illegal,
   output logic               busy
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

   aluop_e dec_aluop;
   logic   dec_imm;
   logic   dec_uses_shamt;
   logic   dec_illegal;
   kind_e  dec_kind;

   alu_decode_comb u_decode (
      .opcode_i     (opcode),
      .funct_i      (funct),
      .aluop_o      (dec_aluop),
      .alusrc_imm_o (dec_imm),
      .uses_shamt_o (dec_uses_shamt),
      .illegal_o    (dec_illegal),
      .kind_o       (dec_kind)
   );

   logic               out_valid_q, out_valid_d;
   logic [ALUOP_W-1:0] aluop_q, aluop_d;
   logic               alusrc_imm_q, alusrc_imm_d;
   logic [4:0]         shamt_q, shamt_d;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic hazard;
   logic in_ready_w;
   logic in_fire;
   logic out_fire;

   // Only HI/LO users wait on the unit; everything else flows past it.
   assign hazard     = (cnt_q != '0) && (is_hilo_start(dec_kind) || is_mfhl(dec_kind));
   assign in_ready_w = (!out_valid_q || out_ready) && !hazard;
   assign in_fire    = in_valid && in_ready_w;
   assign out_fire   = out_valid_q && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      aluop_d      = aluop_q;
      alusrc_imm_d = alusrc_imm_q;
      shamt_d      = shamt_q;
      illegal_d    = illegal_q;
      cnt_d        = cnt_q;

      if (in_fire) begin
         out_valid_d  = 1'b1;
         aluop_d      = ALUOP_W'(dec_aluop);
         alusrc_imm_d = dec_imm;
         shamt_d      = dec_uses_shamt ? shamt : 5'd0;
         illegal_d    = dec_illegal;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end

      // A load never meets a nonzero count: the hazard holds that fire back.
      if (in_fire && dec_kind == KIND_MULT) begin
         cnt_d = MULT_LOAD;
      end else if (in_fire && dec_kind == KIND_DIV) begin
         cnt_d = DIV_LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         aluop_q      <= '0;
         alusrc_imm_q <= 1'b0;
         shamt_q      <= 5'd0;
         illegal_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         aluop_q      <= aluop_d;
         alusrc_imm_q <= alusrc_imm_d;
         shamt_q      <= shamt_d;
         illegal_q    <= illegal_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready   = in_ready_w;
   assign out_valid  = out_valid_q;
   assign aluop      = aluop_q;
   assign alusrc_imm = alusrc_imm_q;
   assign shamt_out  = shamt_q;
   assign illegal    = illegal_q;
   assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus a randomized
// stream checked against a table-driven reference model.
module tb_alu_issue_ctrl;

   localparam int AW = 5;
   localparam int ML = 4;
   localparam int DL = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [5:0]    opcode = 6'h00;
   logic [5:0]    funct = 6'h00;
   logic [4:0]    shamt = 5'd0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] aluop;
   logic          alusrc_imm;
   logic [4:0]    shamt_out;
   logic          illegal;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   alu_issue_ctrl #(.ALUOP_W(AW), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .funct      (funct),
      .shamt      (shamt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .aluop      (aluop),
      .alusrc_imm (alusrc_imm),
      .shamt_out  (shamt_out),
      .illegal    (illegal),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference decode: lookup tables keyed by funct (R-type) and opcode.
   typedef struct {
      int aop;
      bit imm;
      int sh;
      bit ill;
      bit hilo;
      int lat;
   } exp_t;

   int r_tab[int];
   int i_tab[int];
   bit i_imm[int];

   task automatic init_tables();
      r_tab['h00] = 3;  r_tab['h02] = 7;  r_tab['h03] = 8;
      r_tab['h20] = 2;  r_tab['h21] = 2;  r_tab['h22] = 4;  r_tab['h23] = 4;
      r_tab['h24] = 1;  r_tab['h25] = 5;  r_tab['h26] = 9;  r_tab['h27] = 10;
      r_tab['h2A] = 6;  r_tab['h2B] = 11;
      r_tab['h18] = 13; r_tab['h19] = 13; r_tab['h1A] = 14; r_tab['h1B] = 14;
      r_tab['h10] = 15; r_tab['h12] = 15;
      i_tab['h08] = 2;  i_tab['h09] = 2;  i_tab['h0C] = 1;  i_tab['h0D] = 5;
      i_tab['h0E] = 9;  i_tab['h0A] = 6;  i_tab['h0B] = 11; i_tab['h0F] = 12;
      i_tab['h23] = 2;  i_tab['h2B] = 2;  i_tab['h04] = 4;  i_tab['h05] = 4;
      foreach (i_tab[k]) i_imm[k] = (k != 'h04) && (k != 'h05);
   endtask

   function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] sh);
      exp_t e = '{default: 0};
      if (op == 6'h00) begin
         if (r_tab.exists(int'(fn))) e.aop = r_tab[int'(fn)];
         else e.ill = 1'b1;
      end else if (i_tab.exists(int'(op))) begin
         e.aop = i_tab[int'(op)];
         e.imm = i_imm[int'(op)];
      end else begin
         e.ill = 1'b1;
      end
      if (op == 6'h00 && (e.aop == 3 || e.aop == 7 || e.aop == 8)) e.sh = int'(sh);
      e.hilo = (e.aop >= 13);
      e.lat  = (e.aop == 13) ? ML : (e.aop == 14) ? DL : 0;
      return e;
   endfunction

   task automatic idle(input int n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; opcode = 6'h08; funct = 6'h2A; shamt = 5'd9; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
      n_tests++; if (aluop !== AW'(0)) begin n_fail++; $display("FAIL rst_aluop: got %0d want 0", aluop); end
      n_tests++; if (alusrc_imm !== 1'b0) begin n_fail++; $display("FAIL rst_imm: got %0b want 0", alusrc_imm); end
      n_tests++; if (shamt_out !== 5'd0) begin n_fail++; $display("FAIL rst_shamt: got %0d want 0", shamt_out); end
      n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %0b want 0", illegal); end
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b want 1", out_valid); end
      n_tests++; if (aluop !== AW'(2)) begin n_fail++; $display("FAIL addi_aluop: got %0d want 2", aluop); end
      n_tests++; if (alusrc_imm !== 1'b1) begin n_fail++; $display("FAIL addi_imm: got %0b want 1", alusrc_imm); end
      n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal: got %0b want 0", illegal); end
      n_tests++; if (shamt_out !== 5'd0) begin n_fail++; $display("FAIL addi_shamt: got %0d want 0", shamt_out); end
      @(negedge clk);
   endtask

   task automatic test_stream();
      logic [5:0] ops [4] = '{6'h00, 6'h00, 6'h0F, 6'h04};
      logic [5:0] fns [4] = '{6'h00, 6'h22, 6'h11, 6'h07};
      logic [4:0] shs [4] = '{5'd5, 5'd7, 5'd3, 5'd31};
      int e_aop [4] = '{3, 4, 12, 4};
      int e_sh  [4] = '{5, 0, 0, 0};
      bit e_imm [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) begin
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream%0d_valid: got %0b want 1", k - 1, out_valid); end
            n_tests++; if (aluop !== AW'(e_aop[k-1])) begin n_fail++; $display("FAIL stream%0d_aluop: got %0d want %0d", k - 1, aluop, e_aop[k-1]); end
            n_tests++; if (shamt_out !== 5'(e_sh[k-1])) begin n_fail++; $display("FAIL stream%0d_shamt: got %0d want %0d", k - 1, shamt_out, e_sh[k-1]); end
            n_tests++; if (alusrc_imm !== e_imm[k-1]) begin n_fail++; $display("FAIL stream%0d_imm: got %0b want %0b", k - 1, alusrc_imm, e_imm[k-1]); end
         end
         if (k < 4) begin
            opcode = ops[k]; funct = fns[k]; shamt = shs[k]; in_valid = 1'b1;
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream%0d_in_ready: got %0b want 1", k, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      opcode = 6'h00; funct = 6'h24; shamt = 5'd4; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      funct = 6'h25;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready: got %0b want 0", c, in_ready); end
         n_tests++; if (out_valid !== 1'b1 || aluop !== AW'(1) || shamt_out !== 5'd0) begin
            n_fail++; $display("FAIL bp%0d_hold: got valid=%0b aluop=%0d shamt=%0d want 1/1/0", c, out_valid, aluop, shamt_out);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || aluop !== AW'(5)) begin n_fail++; $display("FAIL bp_next: got valid=%0b aluop=%0d want 1/5", out_valid, aluop); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      logic [5:0] ops [2] = '{6'h3F, 6'h00};
      logic [5:0] fns [2] = '{6'h20, 6'h3F};
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         opcode = ops[k]; funct = fns[k]; shamt = 5'd5; in_valid = 1'b1;
         #1;
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill%0d_in_ready: got %0b want 1", k, in_ready); end
         @(negedge clk);
         n_tests++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL ill%0d_flag: got valid=%0b illegal=%0b want 1/1", k, out_valid, illegal); end
         n_tests++; if (aluop !== AW'(0) || alusrc_imm !== 1'b0 || shamt_out !== 5'd0) begin
            n_fail++; $display("FAIL ill%0d_fields: got aluop=%0d imm=%0b shamt=%0d want 0/0/0", k, aluop, alusrc_imm, shamt_out);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mult_interlock();
      int t0;
      int fire_at = -1;
      opcode = 6'h00; funct = 6'h18; shamt = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      t0 = edge_n;
      funct = 6'h20;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_add_unstalled: got %0b want 1", in_ready); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %0b want 1", busy); end
      @(negedge clk);
      n_tests++; if (aluop !== AW'(2)) begin n_fail++; $display("FAIL mul_add_out: got %0d want 2", aluop); end
      funct = 6'h12;
      for (int w = 0; w < 100; w++) begin
         #1;
         if (in_ready) begin fire_at = edge_n + 1; break; end
         @(negedge clk);
      end
      n_tests++; if (fire_at - t0 != ML) begin n_fail++; $display("FAIL mflo_fire_edge: got %0d want %0d", fire_at - t0, ML); end
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || aluop !== AW'(15)) begin n_fail++; $display("FAIL mflo_out: got valid=%0b aluop=%0d want 1/15", out_valid, aluop); end
   endtask

   task automatic test_div_mult();
      int t0;
      int fire_at = -1;
      opcode = 6'h00; funct = 6'h1A; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      t0 = edge_n;
      funct = 6'h18;
      for (int w = 0; w < 100; w++) begin
         #1;
         if (in_ready) begin fire_at = edge_n + 1; break; end
         @(negedge clk);
      end
      n_tests++; if (fire_at - t0 != DL) begin n_fail++; $display("FAIL div_mult_fire_edge: got %0d want %0d", fire_at - t0, DL); end
      @(negedge clk);
      n_tests++; if (aluop !== AW'(13)) begin n_fail++; $display("FAIL div_mult_out: got %0d want 13", aluop); end
      idle(10);
      // Second window: reset lands mid-countdown.
      opcode = 6'h00; funct = 6'h1A; in_valid = 1'b1;
      @(negedge clk);
      funct = 6'h18;
      repeat (9) @(negedge clk);
      #1;
      n_tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL div_window_stall: got in_ready=%0b busy=%0b want 0/1", in_ready, busy); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got busy=%0b valid=%0b want 0/0", busy, out_valid); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %0b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || aluop !== AW'(13) || busy !== 1'b1) begin
         n_fail++; $display("FAIL post_rst_mult: got valid=%0b aluop=%0d busy=%0b want 1/13/1", out_valid, aluop, busy);
      end
   endtask

   task automatic test_random(input int n);
      logic [5:0] op_pool [12] = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h08, 6'h0A,
                                   6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h3F};
      logic [5:0] fn_pool [10] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h12,
                                   6'h18, 6'h1A, 6'h20, 6'h22, 6'h2A};
      bit   m_valid = 1'b0;
      exp_t m_out = '{default: 0};
      int   free_edge = 0;
      exp_t e;
      bit   exp_busy, exp_rdy;
      idle(40);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            opcode = 6'($urandom); funct = 6'($urandom);
         end else begin
            opcode = op_pool[$urandom_range(0, 11)];
            funct  = fn_pool[$urandom_range(0, 9)];
         end
         shamt     = 5'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         e        = ref_decode(opcode, funct, shamt);
         exp_busy = (edge_n < free_edge);
         exp_rdy  = (!m_valid || out_ready) && !(e.hilo && exp_busy);
         n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd%0d_in_ready: got %0b want %0b", i, in_ready, exp_rdy); end
         n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd%0d_busy: got %0b want %0b", i, busy, exp_busy); end
         n_tests++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd%0d_out_valid: got %0b want %0b", i, out_valid, m_valid); end
         if (m_valid) begin
            n_tests++;
            if (aluop !== AW'(m_out.aop) || alusrc_imm !== m_out.imm ||
                shamt_out !== 5'(m_out.sh) || illegal !== m_out.ill) begin
               n_fail++;
               $display("FAIL rnd%0d_fields: got aluop=%0d imm=%0b sh=%0d ill=%0b want %0d/%0b/%0d/%0b",
                        i, aluop, alusrc_imm, shamt_out, illegal, m_out.aop, m_out.imm, m_out.sh, m_out.ill);
            end
         end
         if (in_valid && exp_rdy) begin
            m_out   = e;
            m_valid = 1'b1;
            if (e.lat > 0) free_edge = edge_n + e.lat;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         @(negedge clk);
      end
      idle(2);
   endtask

   initial begin
      init_tables();
      test_reset();
      test_stream();
      test_backpressure();
      test_illegal();
      idle(2);
      test_mult_interlock();
      idle(40);
      test_div_mult();
      test_random(400);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
